m68k_bus_master: RTL
====================

M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 Parameter QDEPTH, default 4, SHALL set request-queue entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 64, SHALL set mc_fall strobes allowed in S4 before abort.
REQ-003 Port sys_clk  in  1 SHALL be the sole clock.
REQ-004 Port sys_rst  in  1 SHALL be the synchronous, active-high reset.
REQ-005 Ports mc_rise/mc_fall  in  1 SHALL be one-sys_clk strobes marking CLK_7M rising/falling edges.
REQ-006 Ports dtack_n, berr_n  in  1; din  in  16 SHALL be pre-synchronized bus inputs.
REQ-007 Ports req_valid in 1, req_ready out 1, req_addr in 24, req_size in 2 (00 byte, 01 word, 11 long), req_read in 1, req_fc in 3, req_wdata in 32 SHALL form the request handshake.
REQ-008 Ports rsp_valid out 1, rsp_rdata out 32, rsp_err out 2 (00 ok, 01 berr, 10 timeout, 11 misaligned) SHALL form the response.
REQ-009 Ports abus out 24, abus_oe, fc out 3, fc_oe, dbus out 16, dbus_oe, as_drive, uds_drive, lds_drive, rw_drive (1 = RnW low), busy out 1 SHALL drive the 68k bus.

Function
REQ-010 Requests SHALL be pushed on req_valid&req_ready; req_ready = queue not full; push and pop in the same cycle while full SHALL be allowed.
REQ-011 In IDLE with queue non-empty, the head SHALL be popped and S0 entered next cycle; busy=1 outside IDLE.
REQ-012 Word/long with req_addr[0]=1 SHALL issue no bus cycle; rsp_valid pulses 1 cycle after pop with rsp_err=11.
REQ-013 S0 on mc_rise -> S1: assert abus_oe, fc_oe, and rw_drive if write.
REQ-014 S1 on mc_fall -> S2: assert as_drive; reads also assert strobes.
REQ-015 S2 on mc_rise -> S3: writes assert dbus_oe.
REQ-016 S3 on mc_fall -> S4: writes assert strobes.
REQ-017 S4 on mc_fall: berr_n=0 -> ERR (berr wins over dtack); else dtack_n=0 -> S5; else wait-count +1.
REQ-018 S5 on mc_rise -> S6; S6 on mc_fall: latch din, deassert as/uds/lds -> S7.
REQ-019 S7 on mc_rise: release all oe and rw_drive; long first half -> S0 at addr+2 (mod 2^24); else pulse rsp_valid -> IDLE.
REQ-020 ERR: deassert as/uds/lds immediately, release bus at next mc_rise, abort any second half, rsp_err=01, rdata=0.
REQ-021 Strobes: byte uds if addr[0]=0 else lds; word/long both.
REQ-022 Byte write dbus={wdata[7:0],wdata[7:0]}; word dbus=wdata[15:0]; long first half wdata[31:16], second wdata[15:0].
REQ-023 Byte read rdata[7:0] = addr[0] ? din[7:0] : din[15:8], upper zero; long first half -> rdata[31:16].
REQ-024 rsp_valid SHALL be a single-cycle pulse with no backpressure.

Reset
REQ-025 sys_rst SHALL empty the queue, enter IDLE, and zero all oe/drive outputs, rsp_valid, busy; req_ready=1 the cycle after.
REQ-026 Reset mid-cycle SHALL release the bus without emitting a response.

Configuration
REQ-027 With BUS_TIMEOUT_EN defined, S4 wait-count reaching TIMEOUT SHALL terminate as ERR with rsp_err=10.
REQ-028 Without BUS_TIMEOUT_EN, no counter SHALL exist and S4 SHALL wait indefinitely.

Structure
REQ-029 Package pistorm_bus_pkg SHALL hold the state enum, size codes, and rsp_err codes.
REQ-030 The queue SHALL be sub-module pistorm_req_fifo (parametrised width/depth, first-word-fall-through).

Verification
REQ-031 Word read 0x00DFF006, dtack_n=0 at first S4 mc_fall, din=0x1234 -> rsp_rdata=0x00001234, err=00, uds=lds=1.
REQ-032 Long write 0x000FFFFE, wdata 0xCAFEBABE -> dbus 0xCAFE at 0x0FFFFE, then 0xBABE at 0x100000.
REQ-033 Byte read 0x000001, din=0xAA55 -> only lds asserted, rdata=0x00000055.
REQ-034 berr_n=0 with dtack_n=0 on long read -> one bus cycle only, err=01.
REQ-035 BUS_TIMEOUT_EN, TIMEOUT=4, no dtack -> err=10 after 4 mc_fall in S4; word at 0x000003 -> err=11, no as_drive.
REQ-036 Push 5 requests with QDEPTH=4 while engine stalled -> req_ready=0 on the 5th; all 4 complete in order.

Source files
------------

// File: rtl/pistorm_bus_pkg.sv
// Shared types for the 68k bus master: FSM states, transfer size codes,
// response error codes and the queued request record.
package pistorm_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_ERR
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_BERR     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_misaligned(req_t r);
    return (r.size != SZ_BYTE) && r.addr[0];
  endfunction

endpackage

// File: rtl/m68k_bus_master_if.sv
// Request/response handshake plus 68k pin-level signals; master = bus master side.
interface m68k_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic        req_read;
  logic [2:0]  req_fc;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  logic        mc_rise;
  logic        mc_fall;
  logic        dtack_n;
  logic        berr_n;
  logic [15:0] din;

  logic [23:0] abus;
  logic        abus_oe;
  logic [2:0]  fc;
  logic        fc_oe;
  logic [15:0] dbus;
  logic        dbus_oe;
  logic        as_drive;
  logic        uds_drive;
  logic        lds_drive;
  logic        rw_drive;
  logic        busy;

  modport master (
    input  req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
    input  mc_rise, mc_fall, dtack_n, berr_n, din,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output abus, abus_oe, fc, fc_oe, dbus, dbus_oe,
    output as_drive, uds_drive, lds_drive, rw_drive, busy
  );

  modport slave (
    output req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
    output mc_rise, mc_fall, dtack_n, berr_n, din,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  abus, abus_oe, fc, fc_oe, dbus, dbus_oe,
    input  as_drive, uds_drive, lds_drive, rw_drive, busy
  );
endinterface

// File: rtl/pistorm_req_fifo.sv
// First-word-fall-through request queue; data_o shows the head while !empty_o.
// A push is accepted while full if a pop happens in the same cycle.
module pistorm_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/m68k_bus_master.sv
// Queued 68000 bus master sequenced by CLK_7M edge strobes; long accesses split into two word cycles.
// BUS_TIMEOUT_EN adds an S4 wait counter that aborts after TIMEOUT mc_fall strobes without DTACK.
module m68k_bus_master
  import pistorm_bus_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 64
) (
  input logic               sys_clk,
  input logic               sys_rst,
  m68k_bus_master_if.master bus
);
  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("m68k_bus_master: QDEPTH must be a power of two >= 2, TIMEOUT >= 1");
  end

  req_t        req_in, head;
  logic        fifo_full, fifo_empty, push, pop;
  state_e      state_q, state_d;
  req_t        cur_q, cur_d;
  logic        half_q, half_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
`ifdef BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  always_comb begin
    req_in       = '0;
    req_in.addr  = bus.req_addr;
    req_in.size  = bus.req_size;
    req_in.read  = bus.req_read;
    req_in.fc    = bus.req_fc;
    req_in.wdata = bus.req_wdata;
  end

  assign push          = bus.req_valid & bus.req_ready;
  assign bus.req_ready = ~fifo_full | pop;

  pistorm_req_fifo #(.WIDTH($bits(req_t)), .DEPTH(QDEPTH)) u_fifo (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .push_i (push),
    .data_i (req_in),
    .pop_i  (pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      half_q      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
`ifdef BUS_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      half_q      <= half_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef BUS_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    half_d      = half_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
`ifdef BUS_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          half_d  = 1'b0;
          rdata_d = '0;
          // Misaligned requests answer straight from IDLE without touching the bus.
          if (is_misaligned(head)) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = ERR_MISALIGN;
          end else begin
            state_d = ST_S0;
          end
        end
      end
      ST_S0: if (bus.mc_rise) state_d = ST_S1;
      ST_S1: if (bus.mc_fall) state_d = ST_S2;
      ST_S2: if (bus.mc_rise) state_d = ST_S3;
      ST_S3: begin
        if (bus.mc_fall) begin
          state_d = ST_S4;
`ifdef BUS_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      ST_S4: begin
        if (bus.mc_fall) begin
          if (!bus.berr_n) begin
            state_d = ST_ERR;
            err_d   = ERR_BERR;
          end else if (!bus.dtack_n) begin
            state_d = ST_S5;
          end else begin
`ifdef BUS_TIMEOUT_EN
            if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
              state_d = ST_ERR;
              err_d   = ERR_TIMEOUT;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
`endif
          end
        end
      end
      ST_S5: if (bus.mc_rise) state_d = ST_S6;
      ST_S6: begin
        if (bus.mc_fall) begin
          if (cur_q.read) begin
            if (cur_q.size == SZ_BYTE)
              rdata_d = {24'h0, cur_q.addr[0] ? bus.din[7:0] : bus.din[15:8]};
            else if (cur_q.size == SZ_LONG && !half_q)
              rdata_d[31:16] = bus.din;
            else if (cur_q.size == SZ_LONG)
              rdata_d[15:0] = bus.din;
            else
              rdata_d = {16'h0, bus.din};
          end
          state_d = ST_S7;
        end
      end
      ST_S7: begin
        if (bus.mc_rise) begin
          if (cur_q.size == SZ_LONG && !half_q) begin
            half_d     = 1'b1;
            cur_d.addr = cur_q.addr + 24'd2;
            state_d    = ST_S0;
          end else begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata_q;
            rsp_err_d   = ERR_OK;
          end
        end
      end
      ST_ERR: begin
        if (bus.mc_rise) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = err_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic in_cycle, as_on, strb_on, byte_sz;

  // ERR keeps address/data driven until the next CLK_7M rise; only AS and strobes drop at once.
  assign in_cycle = state_q inside {ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_ERR};
  assign as_on    = state_q inside {ST_S2, ST_S3, ST_S4, ST_S5, ST_S6};
  assign strb_on  = cur_q.read ? as_on : (state_q inside {ST_S4, ST_S5, ST_S6});
  assign byte_sz  = (cur_q.size == SZ_BYTE);

  assign bus.abus      = cur_q.addr;
  assign bus.abus_oe   = in_cycle;
  assign bus.fc        = cur_q.fc;
  assign bus.fc_oe     = in_cycle;
  assign bus.rw_drive  = in_cycle & ~cur_q.read;
  assign bus.as_drive  = as_on;
  assign bus.uds_drive = strb_on & (~byte_sz | ~cur_q.addr[0]);
  assign bus.lds_drive = strb_on & (~byte_sz | cur_q.addr[0]);
  assign bus.dbus_oe   = ~cur_q.read &
                         (state_q inside {ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_ERR});
  assign bus.dbus      = byte_sz ? {2{cur_q.wdata[7:0]}} :
                         (cur_q.size == SZ_LONG && !half_q) ? cur_q.wdata[31:16] :
                         cur_q.wdata[15:0];
  assign bus.busy      = (state_q != ST_IDLE);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
